// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with a per-register pending-write
// scoreboard. Two combinational read ports plus a debug read port; index
// PC_INDEX has no storage and reads back pc_in. Each storage register carries
// a saturating CNT_W-bit count of issued-but-not-written-back instructions.
// Optional feature: define REGFILE_BYPASS_EN to forward the same-cycle
// writeback data to rd0/rd1 and to retire it from busy0/busy1.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 4,
  parameter int PC_INDEX = (2**ADDR_W) - 1,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] dbg_sel,
  input  logic [WIDTH-1:0]  pc_in,
  output logic [WIDTH-1:0]  rd0,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  dbg_out,
  output logic              busy0,
  output logic              busy1,
  output logic              issue_full,
  output logic              scb_err
);

  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_INDEX);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  // Flattened views of the per-register state, one element per index.
  logic [WIDTH-1:0] rf_data [DEPTH];
  logic [CNT_W-1:0] rf_cnt  [DEPTH];
  logic [DEPTH-1:0] err_vec;
  logic             issue_ok;

  // Refuse an issue whose destination counter is already saturated.
  always_comb begin
    issue_full = 1'b0;
    if (!reset && issue_valid && (issue_dst != PC_ADDR) && (rf_cnt[issue_dst] == CNT_MAX)) begin
      issue_full = 1'b1;
    end
  end

  assign issue_ok = issue_valid && (issue_dst != PC_ADDR) && !issue_full;

  // One storage slot per index; the PC slot is constant and never counts.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi == PC_INDEX) begin : g_pc
      assign rf_data[gi] = '0;
      assign rf_cnt[gi]  = '0;
      assign err_vec[gi] = 1'b0;
    end else begin : g_store
      logic [WIDTH-1:0] data_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             hit_wr;
      logic             hit_iss;
      logic             err_next;

      assign hit_wr  = we && (wa == ADDR_W'(gi));
      assign hit_iss = issue_ok && (issue_dst == ADDR_W'(gi));

      // Issue and writeback to the same slot cancel; a lone writeback to an
      // idle slot is flagged instead of wrapping the counter.
      always_comb begin
        cnt_next = cnt_reg;
        err_next = 1'b0;
        if (hit_iss && !hit_wr) begin
          cnt_next = cnt_reg + CNT_ONE;
        end else if (hit_wr && !hit_iss) begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_ONE;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      // Data and pending count, both cleared the moment reset rises.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (hit_wr) begin
            data_reg <= wd;
          end
          cnt_reg <= cnt_next;
        end
      end

      assign rf_data[gi] = data_reg;
      assign rf_cnt[gi]  = cnt_reg;
      assign err_vec[gi] = err_next;
    end
  end

  // Sticky scoreboard error, only cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scb_err <= 1'b0;
    end else if (|err_vec) begin
      scb_err <= 1'b1;
    end
  end

  // Read ports share one implementation, indexed by port number.
  logic [ADDR_W-1:0] rp_addr [2];
  logic [WIDTH-1:0]  rp_data [2];
  logic              rp_busy [2];

  assign rp_addr[0] = ra0;
  assign rp_addr[1] = ra1;
  assign rd0        = rp_data[0];
  assign rd1        = rp_data[1];
  assign busy0      = rp_busy[0];
  assign busy1      = rp_busy[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
`ifdef REGFILE_BYPASS_EN
    logic fwd;
    assign fwd = !reset && we && (wa == rp_addr[gi]) && (rp_addr[gi] != PC_ADDR);

    // Forward the in-flight writeback; it also retires one pending write.
    always_comb begin
      rp_data[gi] = rf_data[rp_addr[gi]];
      rp_busy[gi] = (rf_cnt[rp_addr[gi]] > CNT_ONE) ||
                    ((rf_cnt[rp_addr[gi]] == CNT_ONE) && !fwd);
      if (rp_addr[gi] == PC_ADDR) begin
        rp_data[gi] = pc_in;
      end else if (fwd) begin
        rp_data[gi] = wd;
      end
    end
`else
    // Stored value only; busy whenever any write is still outstanding.
    always_comb begin
      rp_data[gi] = rf_data[rp_addr[gi]];
      rp_busy[gi] = (rf_cnt[rp_addr[gi]] != '0);
      if (rp_addr[gi] == PC_ADDR) begin
        rp_data[gi] = pc_in;
      end
    end
`endif
  end

  // Debug port always shows the stored state, never forwarded data.
  always_comb begin
    dbg_out = rf_data[dbg_sel];
    if (dbg_sel == PC_ADDR) begin
      dbg_out = pc_in;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: reset readout, a table of directed vectors,
// hand-written multi-cycle corner cases and a randomized run against a
// behavioural model. Expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_scoreboard;

  localparam int PC   = 15;
  localparam int CMAX = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, reset, we, issue_valid;
  logic [3:0]  wa, issue_dst, ra0, ra1, dbg_sel;
  logic [31:0] wd, pc_in, rd0, rd1, dbg_out;
  logic        busy0, busy1, issue_full, scb_err;

  regfile_scoreboard #(.WIDTH(32), .ADDR_W(4), .PC_INDEX(15), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .ra0(ra0), .ra1(ra1), .dbg_sel(dbg_sel), .pc_in(pc_in),
    .rd0(rd0), .rd1(rd1), .dbg_out(dbg_out),
    .busy0(busy0), .busy1(busy1), .issue_full(issue_full), .scb_err(scb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [16];
  int          m_cnt  [16];
  bit          m_err;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] ra);
    if (ra == 4'(PC)) return pc_in;
    if (BYP && we && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  // Outstanding writes not satisfied by this cycle's writeback.
  function automatic logic exp_busy(input logic [3:0] ra);
    int p;
    if (ra == 4'(PC)) return 1'b0;
    p = m_cnt[ra];
    if (BYP && we && wa == ra) p = p - 1;
    return p > 0;
  endfunction

  function automatic logic exp_full();
    return issue_valid && issue_dst != 4'(PC) && m_cnt[issue_dst] == CMAX;
  endfunction

  task automatic model_step();
    bit acc, wr;
    acc = issue_valid && issue_dst != 4'(PC) && !exp_full();
    wr  = we && wa != 4'(PC);
    if (wr) m_regs[wa] = wd;
    if (!(acc && wr && issue_dst == wa)) begin
      if (acc) m_cnt[issue_dst] = m_cnt[issue_dst] + 1;
      if (wr) begin
        if (m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
        else m_err = 1'b1;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
    issue_valid = 1'b0; issue_dst = '0;
    ra0 = '0; ra1 = '0; dbg_sel = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [3:0]  idst;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [31:0] e_rd0;
    logic        e_busy0;
    logic        e_busy1;
    logic        e_full;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [31:0] d,
                              input logic iv, input logic [3:0] idst,
                              input logic [3:0] r0, input logic [3:0] r1,
                              input logic [31:0] erd0, input logic eb0, input logic eb1,
                              input logic ef, input logic ee);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.iv = iv; v.idst = idst; v.ra0 = r0; v.ra1 = r1;
    v.e_rd0 = erd0; v.e_busy0 = eb0; v.e_busy1 = eb1; v.e_full = ef; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl [20];

  function automatic logic [3:0] pick_addr();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'(PC) : 4'(r);
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    pc_in = 32'hDEAD0000;
    model_clear();

    // Reset readout: every index reads 0 except the PC index.
    repeat (2) @(negedge clk);
    issue_valid = 1'b1; issue_dst = 4'd3;
    #1;
    chk("rst_full", {31'b0, issue_full}, 32'h0);
    chk("rst_err", {31'b0, scb_err}, 32'h0);
    issue_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra0 = 4'(i); ra1 = 4'(i); dbg_sel = 4'(i);
      #1;
      chk($sformatf("rst_rd0_%0d", i), rd0, (i == PC) ? 32'hDEAD0000 : 32'h0);
      chk($sformatf("rst_dbg_%0d", i), dbg_out, (i == PC) ? 32'hDEAD0000 : 32'h0);
      chk($sformatf("rst_busy1_%0d", i), {31'b0, busy1}, 32'h0);
      $display("reset read idx=%0d rd0=%h dbg=%h", i, rd0, dbg_out);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Directed table: scoreboard counting, saturation, errors, PC index.
    tbl[0]  = mk(0, 0, 0,          1, 3,  3,  5, 32'h0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,          1, 3,  3,  5, 32'h0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 3, 32'h11,     0, 0,  3,  5, BYP ? 32'h11 : 32'h0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,          0, 0,  3,  5, 32'h11, 1, 0, 0, 0);
    tbl[4]  = mk(1, 3, 32'h22,     0, 0,  3,  5, BYP ? 32'h22 : 32'h11, !BYP, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,          0, 0,  3,  5, 32'h22, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,          1, 5,  3,  5, 32'h22, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,          1, 5,  3,  5, 32'h22, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0,          1, 5,  3,  5, 32'h22, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0,          1, 5,  3,  5, 32'h22, 0, 1, 1, 0);
    tbl[10] = mk(1, 5, 32'h5,      0, 0,  3,  5, 32'h22, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 0,          1, 5,  3,  5, 32'h22, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 0,          1, 5,  3,  5, 32'h22, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 0,          1, 15, 15, 5, 32'hDEAD0000, 0, 1, 0, 0);
    tbl[14] = mk(1, 7, 32'h55,     0, 0,  7,  5, BYP ? 32'h55 : 32'h0, 0, 1, 0, 0);
    tbl[15] = mk(0, 0, 0,          0, 0,  7,  5, 32'h55, 0, 1, 0, 1);
    tbl[16] = mk(1, 8, 32'h88,     1, 8,  8,  5, BYP ? 32'h88 : 32'h0, 0, 1, 0, 1);
    tbl[17] = mk(0, 0, 0,          0, 0,  8,  5, 32'h88, 0, 1, 0, 1);
    tbl[18] = mk(1, 15, 32'h1234,  0, 0,  15, 5, 32'hDEAD0000, 0, 1, 0, 1);
    tbl[19] = mk(0, 0, 0,          0, 0,  15, 7, 32'hDEAD0000, 0, 0, 0, 1);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      issue_valid = tbl[i].iv; issue_dst = tbl[i].idst;
      ra0 = tbl[i].ra0; ra1 = tbl[i].ra1; dbg_sel = tbl[i].ra0;
      #1;
      chk($sformatf("tbl%0d_rd0", i), rd0, tbl[i].e_rd0);
      chk($sformatf("tbl%0d_busy0", i), {31'b0, busy0}, {31'b0, tbl[i].e_busy0});
      chk($sformatf("tbl%0d_busy1", i), {31'b0, busy1}, {31'b0, tbl[i].e_busy1});
      chk($sformatf("tbl%0d_full", i), {31'b0, issue_full}, {31'b0, tbl[i].e_full});
      chk($sformatf("tbl%0d_err", i), {31'b0, scb_err}, {31'b0, tbl[i].e_err});
      $display("vec %0d we=%0d wa=%0d iv=%0d dst=%0d ra0=%0d rd0=%h b0=%0d b1=%0d full=%0d err=%0d",
               i, we, wa, issue_valid, issue_dst, ra0, rd0, busy0, busy1, issue_full, scb_err);
    end

    // Same-cycle issue and writeback to an idle register: no error, count stays 0.
    do_reset();
    we = 1'b1; wa = 4'd8; wd = 32'h88; issue_valid = 1'b1; issue_dst = 4'd8;
    @(negedge clk);
    idle(); ra0 = 4'd8;
    #1;
    chk("same_cycle_err", {31'b0, scb_err}, 32'h0);
    chk("same_cycle_busy", {31'b0, busy0}, 32'h0);
    chk("same_cycle_rd0", rd0, 32'h88);
    $display("same-cycle r8 err=%0d busy0=%0d rd0=%h", scb_err, busy0, rd0);

    // Forwarding case: cnt[2]=1, writeback to r2 seen on ra1 in the same cycle.
    do_reset();
    we = 1'b1; wa = 4'd2; wd = 32'h1111; issue_valid = 1'b1; issue_dst = 4'd2;
    @(negedge clk);
    idle(); issue_valid = 1'b1; issue_dst = 4'd2;
    @(negedge clk);
    idle(); we = 1'b1; wa = 4'd2; wd = 32'hABCD; ra1 = 4'd2; dbg_sel = 4'd2;
    #1;
    chk("fwd_rd1", rd1, BYP ? 32'hABCD : 32'h1111);
    chk("fwd_busy1", {31'b0, busy1}, BYP ? 32'h0 : 32'h1);
    chk("fwd_dbg", dbg_out, 32'h1111);
    chk("fwd_err", {31'b0, scb_err}, 32'h0);
    $display("forward r2 rd1=%h busy1=%0d dbg=%h", rd1, busy1, dbg_out);

    // Reset between edges with cnt[4]=2: busy drops at once, write is lost.
    do_reset();
    issue_valid = 1'b1; issue_dst = 4'd4;
    @(negedge clk);
    @(negedge clk);
    idle(); ra0 = 4'd4;
    #1;
    chk("midrst_busy_pre", {31'b0, busy0}, 32'h1);
    we = 1'b1; wa = 4'd4; wd = 32'h44;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy0}, 32'h0);
    chk("midrst_rd0", rd0, 32'h0);
    chk("midrst_err", {31'b0, scb_err}, 32'h0);
    @(negedge clk);
    idle(); ra0 = 4'd4;
    reset = 1'b0;
    #1;
    chk("midrst_lost", rd0, 32'h0);
    chk("midrst_busy_post", {31'b0, busy0}, 32'h0);
    $display("mid-cycle reset busy0=%0d rd0=%h", busy0, rd0);
    model_clear();

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we = ($urandom_range(0, 2) == 0);
      wa = pick_addr();
      wd = $urandom;
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_dst = pick_addr();
      ra0 = pick_addr(); ra1 = pick_addr(); dbg_sel = pick_addr();
      pc_in = $urandom;
      #1;
      chk($sformatf("rnd%0d_rd0", n), rd0, exp_rd(ra0));
      chk($sformatf("rnd%0d_rd1", n), rd1, exp_rd(ra1));
      chk($sformatf("rnd%0d_dbg", n), dbg_out, (dbg_sel == 4'(PC)) ? pc_in : m_regs[dbg_sel]);
      chk($sformatf("rnd%0d_busy0", n), {31'b0, busy0}, {31'b0, exp_busy(ra0)});
      chk($sformatf("rnd%0d_busy1", n), {31'b0, busy1}, {31'b0, exp_busy(ra1)});
      chk($sformatf("rnd%0d_full", n), {31'b0, issue_full}, {31'b0, exp_full()});
      chk($sformatf("rnd%0d_err", n), {31'b0, scb_err}, {31'b0, m_err});
      $display("rnd %0d we=%0d wa=%0d iv=%0d dst=%0d full=%0d err=%0d",
               n, we, wa, issue_valid, issue_dst, issue_full, scb_err);
      model_step();
    end

    @(negedge clk);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
